// File: rtl/ram_seq_reader_if.sv
// Stream handshake bundle for ram_seq_reader.
// master drives data/valid, slave drives ready.
interface ram_seq_reader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/ram_seq_reader.sv
// Sequential RAM read-back engine with 2-entry output FIFO.
// Optional pattern checker built when RAM_RD_CHECK_EN is defined.
module ram_seq_reader #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base,
  input  logic [AW:0]           len,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_wr,
  input  logic [DW-1:0]         ram_q,
  ram_seq_reader_if.master      s,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        st;
  logic [AW:0]   icnt;
  logic [AW:0]   rcnt;
  logic [DW-1:0] head, tail;
  logic [DW-1:0] head_n, tail_n;
  logic [1:0]    occ, occ_n;
  logic          infl;
  logic          vld;
  logic          pop;
  logic          issue;

  assign ram_wr       = 1'b0;
  assign s.dout       = head;
  assign s.dout_valid = vld;

  assign pop = vld & s.dout_ready;

  // occupancy + inflight - pop must stay below 2 after issuing
  assign issue = (st == RUN) && (icnt != '0) &&
                 (({1'b0, occ} + {2'b0, infl}) <
                  (3'd2 + {2'b0, pop}));

  always_comb begin
    occ_n  = occ;
    head_n = head;
    tail_n = tail;
    unique case (occ)
      2'd0: begin
        if (infl) begin
          head_n = ram_q;
          occ_n  = 2'd1;
        end
      end
      2'd1: begin
        if (infl && pop) begin
          head_n = ram_q;
        end else if (infl) begin
          tail_n = ram_q;
          occ_n  = 2'd2;
        end else if (pop) begin
          occ_n  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_n = tail;
          if (infl) begin
            tail_n = ram_q;
            occ_n  = 2'd2;
          end else begin
            occ_n  = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      icnt     <= '0;
      rcnt     <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      infl     <= 1'b0;
      vld      <= 1'b0;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      infl <= issue;
      occ  <= occ_n;
      head <= head_n;
      tail <= tail_n;
      vld  <= (occ_n != 2'd0);
      if (issue) begin
        ram_addr <= ram_addr + 1'b1;
        icnt     <= icnt - 1'b1;
      end
      if (pop) begin
        rcnt <= rcnt - 1'b1;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            ram_addr <= base;
            icnt     <= len;
            rcnt     <= len;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              st   <= RUN;
              busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && icnt == 1) begin
            st <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && rcnt == 1) begin
            done <= 1'b1;
            busy <= 1'b0;
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef RAM_RD_CHECK_EN
  logic [AW-1:0] cap_addr;
  logic          mism;

  // mism registers the compare at capture; err follows one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_addr <= '0;
      mism     <= 1'b0;
      err      <= 1'b0;
    end else if (st == IDLE && start) begin
      mism <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (issue) begin
        cap_addr <= ram_addr;
      end
      mism <= infl && (ram_q != DW'(cap_addr));
      err  <= err | mism;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_seq_reader.sv
// Randomized self-checking bench for ram_seq_reader.
// Reference: queue of expected words from a 64x8 RAM model.
module tb_ram_seq_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] base;
  logic [6:0] len;
  logic [5:0] ram_addr;
  logic       ram_wr;
  logic [7:0] ram_q;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] mem [64];

  int total;
  int bad;

`ifdef RAM_RD_CHECK_EN
  localparam int ERRC = 9;
`else
  localparam int ERRC = -1;
`endif

  ram_seq_reader_if #(.DW(8)) bus ();

  ram_seq_reader #(.DW(8), .AW(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .len      (len),
    .ram_addr (ram_addr),
    .ram_wr   (ram_wr),
    .ram_q    (ram_q),
    .s        (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic chk_idle(input string nm);
    total++;
    if (ram_addr !== 6'd0 || ram_wr !== 1'b0 || bus.dout !== 8'd0 ||
        bus.dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0) begin
      bad++;
      $display("FAIL %s got addr=%0h wr=%b dout=%0h v=%b busy=%b done=%b err=%b exp all 0",
               nm, ram_addr, ram_wr, bus.dout, bus.dout_valid, busy, done, err);
    end
  endtask

  task automatic run(input int b, input int n, input int mode,
                     input bit timing, input int err_cyc);
    logic [7:0] exp_q [$];
    int  pops, cyc, stall_at, issued;
    bit  seen, exp_done, exp_busy, exp_err, rdy;
    pops = 0;
    seen = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 64]);
    stall_at = $urandom_range(6, 12);
    start = 1'b1;
    base  = 6'(b);
    len   = 7'(n);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!seen && cyc < 600) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= stall_at && cyc < stall_at + 10) ? 1'b0 : cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.dout_ready = rdy;
      if (mode == 1 && cyc == 4) begin
        start = 1'b1;
        base  = ~base;
        len   = 7'd3;
      end else begin
        start = 1'b0;
      end
      exp_done = (pops == n);
      exp_busy = (n > 0) && (pops < n);
      exp_err  = (err_cyc >= 0) && (cyc >= err_cyc);
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
      end
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      total++;
      if (err !== exp_err) begin
        bad++;
        $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, exp_err);
      end
      total++;
      if (ram_wr !== 1'b0) begin
        bad++;
        $display("FAIL ram_wr cyc=%0d got=%b exp=0", cyc, ram_wr);
      end
      if (mode != 0 && n < 64) begin
        issued = int'(6'(ram_addr - 6'(b)));
        total++;
        if (issued > pops + 2) begin
          bad++;
          $display("FAIL ahead cyc=%0d got issued=%0d exp<=%0d", cyc, issued, pops + 2);
        end
      end
      if (done === 1'b1) seen = 1'b1;
      if (bus.dout_valid === 1'b1 && rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word cyc=%0d got=%0h exp=none", cyc, bus.dout);
        end else begin
          if (bus.dout !== exp_q[0]) begin
            bad++;
            $display("FAIL data idx=%0d got=%0h exp=%0h", pops, bus.dout, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (timing) begin
          total++;
          if (cyc != pops + 3) begin
            bad++;
            $display("FAIL latency idx=%0d got cyc=%0d exp=%0d", pops, cyc, pops + 3);
          end
        end
        pops++;
      end
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL timeout got=no_done exp=done base=%0d len=%0d", b, n);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing got=%0d left exp=0", exp_q.size());
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || bus.dout_valid !== 1'b0 || busy !== 1'b0 ||
          err !== (err_cyc >= 0)) begin
        bad++;
        $display("FAIL post_done got done=%b v=%b busy=%b err=%b exp 0 0 0 %b",
                 done, bus.dout_valid, busy, err, err_cyc >= 0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    base  = '0;
    len   = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_released");
  endtask

  task automatic test_len_zero();
    run(int'($urandom_range(0, 63)), 0, 0, 1'b1, -1);
  endtask

  task automatic test_full();
    run(0, 64, 0, 1'b1, -1);
  endtask

  task automatic test_wrap();
    run(60, 8, 0, 1'b1, -1);
  endtask

  task automatic test_backpressure();
    run(int'($urandom_range(0, 63)), 16, 1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run(int'($urandom_range(0, 63)), int'($urandom_range(1, 64)), 2, 1'b0, -1);
    end
  endtask

  task automatic test_mid_reset();
    int pops, cyc;
    pops = 0;
    cyc  = 0;
    start = 1'b1;
    base  = 6'($urandom_range(0, 63));
    len   = 7'd20;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (pops < 5 && cyc < 50) begin
      if (bus.dout_valid === 1'b1) pops++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (pops != 5) begin
      bad++;
      $display("FAIL mid_pops got=%0d exp=5", pops);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("mid_reset");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || bus.dout_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL after_reset got done=%b v=%b busy=%b exp 0 0 0",
                 done, bus.dout_valid, busy);
      end
    end
    run(int'($urandom_range(0, 63)), 4, 0, 1'b1, -1);
  endtask

  task automatic test_check();
    mem[5] = 8'hAA;
    run(0, 8, 0, 1'b1, ERRC);
    mem[5] = 8'h05;
    run(0, 4, 0, 1'b1, -1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    test_reset();
    test_len_zero();
    test_full();
    test_wrap();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
